// File: rtl/nclassic_disp_spi_sink.sv
// nclassic_disp_spi_sink
// Write-only SPI responder modelling an SSD1326-style OLED controller.
// It deserialises command/data bytes, decodes the column/row window and
// display on/off commands, and auto-increments through a 128x32 byte GDDRAM.
// The GDDRAM can be read back through a separate read port.
//
// Ports:
//   clk_in, reset_in  system clock, synchronous active-high reset
//   disp_cs_n_in      SPI chip select (active low)
//   disp_sck_in       SPI clock, data sampled on its rising edge
//   disp_data_in      SPI MOSI, MSB first
//   disp_addr_in      D/C: 1 = GDDRAM data, 0 = command/parameter
//   rd_addr_in        read address {row[4:0], col[6:0]}
//   rd_data_o         GDDRAM byte at rd_addr_in, 1-cycle latency
//   disp_on_o         display enable (0xAF sets, 0xAE clears)
//   byte_valid_o      one-cycle pulse per completed byte
//   byte_o, byte_dc_o last completed byte and its D/C value
//   drop_o            one-cycle pulse when CS is released mid-byte
module nclassic_disp_spi_sink #(
  parameter int unsigned COLS = 128,
  parameter int unsigned ROWS = 32
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        disp_cs_n_in,
  input  logic        disp_sck_in,
  input  logic        disp_data_in,
  input  logic        disp_addr_in,
  input  logic [11:0] rd_addr_in,
  output logic [7:0]  rd_data_o,
  output logic        disp_on_o,
  output logic        byte_valid_o,
  output logic [7:0]  byte_o,
  output logic        byte_dc_o,
  output logic        drop_o
);

  localparam int unsigned DEPTH = COLS * ROWS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COL_S,
    ST_COL_E,
    ST_ROW_S,
    ST_ROW_E
  } state_t;

  // Input synchronisers: *_meta_q is the first stage, *_q1 the synchronised
  // value, sck_q2 a one-cycle delayed copy used for rising-edge detection.
  logic cs_meta_q, cs_q1;
  logic sck_meta_q, sck_q1, sck_q2;
  logic data_meta_q, data_q1;
  logic addr_meta_q, addr_q1;
  logic sck_rise;

  // Deserialiser
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_dc_q, byte_dc_d;
  logic       valid_q, valid_d;
  logic       drop_q, drop_d;

  // Command decoder and write pointers
  state_t     state_q, state_d;
  logic [6:0] col_start_q, col_start_d;
  logic [6:0] col_end_q, col_end_d;
  logic [4:0] row_start_q, row_start_d;
  logic [4:0] row_end_q, row_end_d;
  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       disp_on_q, disp_on_d;
  logic       ram_we;

  // GDDRAM
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cs_meta_q   <= 1'b1;
      cs_q1       <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_q1      <= 1'b0;
      sck_q2      <= 1'b0;
      data_meta_q <= 1'b0;
      data_q1     <= 1'b0;
      addr_meta_q <= 1'b0;
      addr_q1     <= 1'b0;
    end else begin
      cs_meta_q   <= disp_cs_n_in;
      cs_q1       <= cs_meta_q;
      sck_meta_q  <= disp_sck_in;
      sck_q1      <= sck_meta_q;
      sck_q2      <= sck_q1;
      data_meta_q <= disp_data_in;
      data_q1     <= data_meta_q;
      addr_meta_q <= disp_addr_in;
      addr_q1     <= addr_meta_q;
    end
  end

  assign sck_rise = sck_q1 & ~sck_q2;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    byte_dc_d = byte_dc_q;
    valid_d   = 1'b0;
    drop_d    = 1'b0;
    if (cs_q1) begin
      // Partial byte is discarded; only the drop pulse reports it.
      bit_cnt_d = '0;
      drop_d    = (bit_cnt_q != 3'd0);
    end else if (sck_rise) begin
      shift_d   = {shift_q[5:0], data_q1};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d    = {shift_q, data_q1};
        byte_dc_d = addr_q1;
        valid_d   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    col_d       = col_q;
    row_d       = row_q;
    disp_on_d   = disp_on_q;
    ram_we      = 1'b0;
    if (valid_q) begin
      if (byte_dc_q) begin
        // Data aborts any pending parameter sequence; registers already
        // written by that sequence keep their new values.
        state_d = ST_IDLE;
        ram_we  = 1'b1;
        if (col_q == col_end_q) begin
          col_d = col_start_q;
          row_d = (row_q == row_end_q) ? row_start_q : row_q + 5'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            unique case (byte_q)
              8'h15:   state_d = ST_COL_S;
              8'h75:   state_d = ST_ROW_S;
              8'hAF:   disp_on_d = 1'b1;
              8'hAE:   disp_on_d = 1'b0;
              default: state_d = ST_IDLE;
            endcase
          end
          ST_COL_S: begin
            col_start_d = byte_q[6:0];
            state_d     = ST_COL_E;
          end
          ST_COL_E: begin
            col_end_d = (byte_q[6:0] < col_start_q) ? col_start_q : byte_q[6:0];
            col_d     = col_start_q;
            state_d   = ST_IDLE;
          end
          ST_ROW_S: begin
            row_start_d = byte_q[4:0];
            state_d     = ST_ROW_E;
          end
          ST_ROW_E: begin
            row_end_d = (byte_q[4:0] < row_start_q) ? row_start_q : byte_q[4:0];
            row_d     = row_start_q;
            state_d   = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_q      <= '0;
      byte_dc_q   <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
      state_q     <= ST_IDLE;
      col_start_q <= '0;
      col_end_q   <= 7'd127;
      row_start_q <= '0;
      row_end_q   <= 5'd31;
      col_q       <= '0;
      row_q       <= '0;
      disp_on_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      byte_dc_q   <= byte_dc_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      col_q       <= col_d;
      row_q       <= row_d;
      disp_on_q   <= disp_on_d;
    end
  end

  // RAM is not reset; a same-cycle read of the written address sees old data.
  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      mem[{row_q, col_q}] <= byte_q;
    end
    rd_data_q <= mem[rd_addr_in];
  end

  assign rd_data_o    = rd_data_q;
  assign disp_on_o    = disp_on_q;
  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign byte_dc_o    = byte_dc_q;
  assign drop_o       = drop_q;

endmodule
